// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//   One request may be outstanding at a time; a request is a single-cycle
//   pulse that memory always accepts, and the response arrives one or more
//   cycles later.
//
//   Signals
//     req     fetch request pulse (fetch -> memory)
//     addr    fetch address, meaningful while req=1 (fetch -> memory)
//     rvalid  response valid (memory -> fetch)
//     rdata   instruction word, meaningful with rvalid (memory -> fetch)
//
//   Modports
//     master  fetch-stage side
//     slave   instruction-memory side
// ---------------------------------------------------------------------------
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage, producer side of the IF/ID pipeline register.
//   Holds the PC, issues one instruction-memory request at a time and
//   presents {pc_o, inst_o, valid_o} to IF/ID. A hazard stall holds the
//   presented instruction; a redirect (taken branch / flush) reloads the PC
//   and turns the presented slot into an all-zero bubble. A redirect that
//   arrives while a request is in flight marks that response to be dropped.
//
//   Ports
//     clk_i          clock, rising edge
//     rst_i          synchronous active-high reset (shared with memory)
//     stall_i        hazard stall, IF/ID holds this cycle
//     redirect_i     flush / branch taken, PC <= redirect_pc_i
//     redirect_pc_i  redirect target (no alignment check)
//     imem           instruction-memory bus (master side)
//     pc_o           PC of presented instruction (registered)
//     inst_o         presented instruction, 0 for a bubble (registered)
//     valid_o        presented instruction is real (registered)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [31:0]         redirect_pc_i,
   fetch_unit_if.master        imem,
   output logic [31:0]         pc_o,
   output logic [31:0]         inst_o,
   output logic                valid_o
);

   typedef enum logic [0:0] {
      ST_ISSUE = 1'b0,
      ST_WAIT  = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_n;
   logic [31:0] pc_r;
   logic [31:0] pc_n;
   logic [31:0] fetch_pc_r;
   logic [31:0] fetch_pc_n;
   logic        kill_r;
   logic        kill_n;

   logic        req_s;
   logic        load_s;
   logic [31:0] pc_out_n;
   logic [31:0] inst_out_n;
   logic        valid_out_n;

   // Request gating: never issue while a presented instruction is stalled,
   // so valid_o is always 0 when a response lands and no skid buffer is needed.
   always_comb begin
      req_s = (state_r == ST_ISSUE) && !redirect_i && !(valid_o && stall_i) && !rst_i;
   end

   assign imem.req  = req_s;
   assign imem.addr = pc_r;

   // Fetch FSM next-state: PC sequencing, in-flight tracking and kill marking.
   always_comb begin
      state_n    = state_r;
      pc_n       = pc_r;
      fetch_pc_n = fetch_pc_r;
      kill_n     = kill_r;
      case (state_r)
         ST_ISSUE: begin
            if (redirect_i) begin
               pc_n = redirect_pc_i;
            end else if (req_s) begin
               fetch_pc_n = pc_r;
               pc_n       = pc_r + PC_STEP;
               state_n    = ST_WAIT;
            end else begin
               state_n = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (imem.rvalid) begin
               // Response closes the transaction whether it is kept or dropped.
               kill_n  = 1'b0;
               state_n = ST_ISSUE;
               if (redirect_i) begin
                  pc_n = redirect_pc_i;
               end else begin
                  pc_n = pc_r;
               end
            end else if (redirect_i) begin
               // Redirect with a request in flight: its data must be discarded.
               kill_n = 1'b1;
               pc_n   = redirect_pc_i;
            end else begin
               kill_n = kill_r;
            end
         end
         default: begin
            state_n = ST_ISSUE;
         end
      endcase
   end

   // Presented-instruction next value: redirect beats load beats consume.
   always_comb begin
      load_s      = (state_r == ST_WAIT) && imem.rvalid && !kill_r;
      pc_out_n    = pc_o;
      inst_out_n  = inst_o;
      valid_out_n = valid_o;
      if (redirect_i) begin
         pc_out_n    = 32'h0000_0000;
         inst_out_n  = 32'h0000_0000;
         valid_out_n = 1'b0;
      end else if (load_s) begin
         pc_out_n    = fetch_pc_r;
         inst_out_n  = imem.rdata;
         valid_out_n = 1'b1;
      end else if (valid_o && !stall_i) begin
         // IF/ID consumed the instruction; present a bubble.
         pc_out_n    = 32'h0000_0000;
         inst_out_n  = 32'h0000_0000;
         valid_out_n = 1'b0;
      end else begin
         pc_out_n    = pc_o;
         inst_out_n  = inst_o;
         valid_out_n = valid_o;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_ISSUE;
         pc_r       <= RESET_PC;
         fetch_pc_r <= 32'h0000_0000;
         kill_r     <= 1'b0;
         pc_o       <= 32'h0000_0000;
         inst_o     <= 32'h0000_0000;
         valid_o    <= 1'b0;
      end else begin
         state_r    <= state_n;
         pc_r       <= pc_n;
         fetch_pc_r <= fetch_pc_n;
         kill_r     <= kill_n;
         pc_o       <= pc_out_n;
         inst_o     <= inst_out_n;
         valid_o    <= valid_out_n;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A variable-latency instruction memory
//   answers requests; a transaction-level model (next PC, one outstanding
//   fetch with a drop flag, one presented slot) predicts req/addr and the
//   presented outputs every cycle. Directed scenarios pin the model with
//   literal expectations, then a randomized phase mixes stalls, redirects,
//   resets, stray responses and latencies of 1..4 cycles.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;

   always #5 clk = ~clk;

   fetch_unit_if imem();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem          (imem),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .valid_o       (valid_o)
   );

   int checks = 0;
   int errors = 0;

   // memory environment
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   int          mem_cnt  = 0;
   int          lat      = 1;
   bit          junk_en  = 1'b0;

   // reference model
   bit          m_known = 1'b0;
   logic [31:0] m_pc    = 32'h0;
   logic [31:0] m_fpc   = 32'h0;
   bit          m_busy  = 1'b0;
   bit          m_kill  = 1'b0;
   bit          m_v     = 1'b0;
   logic [31:0] m_pco   = 32'h0;
   logic [31:0] m_inst  = 32'h0;

   logic        last_req;
   logic [31:0] last_addr;

   function automatic logic [31:0] memword(input logic [31:0] a);
      case (a)
         32'h0000_0000: memword = 32'h00A0_0093;
         32'h0000_0004: memword = 32'h0010_0113;
         default:       memword = a ^ 32'h5A5A_0013;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [31:0] pc, input logic [31:0] inst);
      chk({name, ".valid"}, {31'd0, valid_o}, {31'd0, v});
      chk({name, ".pc"}, pc_o, pc);
      chk({name, ".inst"}, inst_o, inst);
   endtask

   // One clock cycle: entered at posedge+1, leaves at the next posedge+1.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
      bit          exp_req;
      bit          deliver;
      logic        rv;
      logic [31:0] rdat;
      rst = r; stall = s; redirect = rd; redirect_pc = rp;
      if (r) begin
         mem_pend = 1'b0;
         imem.rvalid = 1'b0;
         imem.rdata  = 32'h0;
      end else if (mem_pend && mem_cnt <= 1) begin
         imem.rvalid = 1'b1;
         imem.rdata  = memword(mem_addr);
         mem_pend    = 1'b0;
      end else begin
         if (mem_pend) mem_cnt--;
         if (!mem_pend && junk_en && $urandom_range(0, 9) == 0) begin
            imem.rvalid = 1'b1;
            imem.rdata  = $urandom;
         end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = 32'h0;
         end
      end
      @(negedge clk);
      last_req  = imem.req;
      last_addr = imem.addr;
      rv   = imem.rvalid;
      rdat = imem.rdata;
      exp_req = !m_busy && !rd && !(m_v && s) && !r;
      if (m_known) begin
         chk("req", {31'd0, imem.req}, {31'd0, exp_req});
         if (exp_req) chk("addr", imem.addr, m_pc);
         chk("valid_o", {31'd0, valid_o}, {31'd0, m_v});
         chk("pc_o", pc_o, m_pco);
         chk("inst_o", inst_o, m_inst);
      end
      if (imem.req && !r) begin
         mem_pend = 1'b1;
         mem_addr = imem.addr;
         mem_cnt  = lat;
      end
      // model update for the coming edge
      if (r) begin
         m_known = 1'b1; m_pc = 32'h0; m_busy = 1'b0; m_kill = 1'b0;
         m_v = 1'b0; m_pco = 32'h0; m_inst = 32'h0;
      end else if (m_known) begin
         deliver = m_busy && rv && !m_kill && !rd;
         if (rd) begin
            m_v = 1'b0; m_pco = 32'h0; m_inst = 32'h0;
         end else if (deliver) begin
            m_v = 1'b1; m_pco = m_fpc; m_inst = rdat;
         end else if (m_v && !s) begin
            m_v = 1'b0; m_pco = 32'h0; m_inst = 32'h0;
         end
         if (!m_busy) begin
            if (rd) m_pc = rp;
            else if (exp_req) begin
               m_fpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1;
            end
         end else if (rv) begin
            m_busy = 1'b0; m_kill = 1'b0;
            if (rd) m_pc = rp;
         end else if (rd) begin
            m_kill = 1'b1; m_pc = rp;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        r;
      logic        s;
      logic        rd;
      logic [31:0] rp;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem.rvalid = 1'b0; imem.rdata = 32'h0;
      @(posedge clk);
      #1;

      // 1: reset for two cycles
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1.req0", {31'd0, last_req}, 32'd0);
      chk_out("t1.rst0", 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1.req1", {31'd0, last_req}, 32'd0);
      chk_out("t1.rst1", 1'b0, 32'h0, 32'h0);

      // 2: L=1 back-to-back fetches
      lat = 1;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t1.first_req", {31'd0, last_req}, 32'd1);
      chk("t1.first_addr", last_addr, 32'h0000_0000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t2.wait_noreq", {31'd0, last_req}, 32'd0);
      chk_out("t2.inst0", 1'b1, 32'h0000_0000, 32'h00A0_0093);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t2.req4", {31'd0, last_req}, 32'd1);
      chk("t2.addr4", last_addr, 32'h0000_0004);
      chk_out("t2.bubble", 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk_out("t2.inst4", 1'b1, 32'h0000_0004, 32'h0010_0113);

      // 3: stall holds the presented instruction and blocks issue
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         chk("t3.noreq", {31'd0, last_req}, 32'd0);
         chk_out("t3.hold", 1'b1, 32'h0000_0004, 32'h0010_0113);
      end
      lat = 3;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t3.req8", {31'd0, last_req}, 32'd1);
      chk("t3.addr8", last_addr, 32'h0000_0008);

      // 4: redirect while waiting on a slow response drops it
      step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
      chk_out("t4.redir", 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk_out("t4.wait", 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk_out("t4.dropped", 1'b0, 32'h0, 32'h0);
      lat = 1;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t4.req40", {31'd0, last_req}, 32'd1);
      chk("t4.addr40", last_addr, 32'h0000_0040);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk_out("t4.inst40", 1'b1, 32'h0000_0040, 32'h0000_0040 ^ 32'h5A5A_0013);

      // 5: redirect beats stall
      step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
      chk_out("t5.flush", 1'b0, 32'h0, 32'h0);

      // 6: PC wrap
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t6.addr_top", last_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk_out("t6.inst_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ 32'h5A5A_0013);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t6.wrap_req", {31'd0, last_req}, 32'd1);
      chk("t6.wrap_addr", last_addr, 32'h0000_0000);

      // randomized phase
      junk_en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 4))
            0: rp = 32'hFFFF_FFFC;
            1: rp = 32'hFFFF_FFF8;
            2: rp = $urandom;
            default: rp = $urandom & 32'h0000_0FFC;
         endcase
         lat = $urandom_range(1, 4);
         step(r, s, rd, rp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
